step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Pattern step sequencer; plays a stored note pattern into the audio voice datapath at a sample-counted tempo.
//  - One step per SPS samples. Each step drives a phase-increment frequency (oscillator freq_N input) and a gate (envelope_generator gate).
//  - CPU loads the pattern through a parameter write port; sample timing comes from DACLRC.
// PARAMETERS
//  STEPS      16  pattern depth in entries (power of 2)
//  FREQ_BITS  16  frequency word width; matches oscillator PHASE_SIZE
//  CNT_BITS   16  width of the tempo and gate-length counters
// PORTS
//  clk         in   1           system clock (OSC, 49.152 MHz)
//  rst         in   1           synchronous reset, active high
//  lrclk       in   1           DACLRC, asynchronous to clk; rising edge = one sample
//  start       in   1           pulse: begin playback from step 0
//  stop        in   1           pulse: halt playback
//  wr_en       in   1           pattern write strobe
//  wr_addr     in   log2(STEPS) pattern entry index
//  wr_data     in   FREQ_BITS+2 {gate, tie, freq}
//  sps         in   CNT_BITS    samples per step; 0 is treated as 1
//  gate_len    in   CNT_BITS    samples the gate stays high within a step
//  loop_end    in   log2(STEPS) last step index before wrap to 0
//  swing       in   8           swing samples (SWING_STEP_EN only)
//  freq        out  FREQ_BITS   current step frequency word
//  gate        out  1           envelope gate
//  step        out  log2(STEPS) current step index
//  step_strobe out  1           one-clk pulse at every step start
//  running     out  1           high while playing
// BEHAVIOUR
//  - Reset: freq=0, gate=0, step=0, step_strobe=0, running=0; state=STOPPED. Pattern RAM contents are not cleared.
//  - Sample tick: lrclk passes a 2-FF synchroniser, then a rising-edge detect. Tick is a one-clk pulse, 3 clk after the lrclk edge.
//  - Pattern RAM: written synchronously on wr_en. An entry is read only at step start and latched, so an edit to the playing step takes effect on its next visit.
//  - States: STOPPED, ARMED, GATE_HI, GATE_LO, RETRIG.
//    - STOPPED: on start -> ARMED, running=1.
//    - ARMED: on the next tick, load step 0 and pulse step_strobe. Go to GATE_HI if entry.gate=1, else GATE_LO.
//    - GATE_HI: gate=1. After gate_len ticks -> GATE_LO (gate_len=0 means the gate never rises).
//    - GATE_LO: gate=0. Wait for the step boundary.
//    - Step boundary: after sps ticks since step start, step <= (step==min(loop_end,STEPS-1)) ? 0 : step+1.
//      - Next entry has gate=1 and tie=1, and gate is currently high: stay in GATE_HI (legato); only freq changes.
//      - Next entry has gate=1, tie=0, and gate is currently high: go to RETRIG. gate=0 for exactly one tick, then GATE_HI, so the envelope re-attacks.
//  - gate_len >= sps: gate is high for the whole step.
//  - freq updates at step start for every step, gated or not. freq holds through GATE_LO so the release phase keeps its pitch.
//  - stop, in any state: next clk gate=0, running=0, step=0, state=STOPPED; freq holds.
//    - start and stop in the same clk: stop wins.
//    - start while running: restart at ARMED; gate drops immediately.
//  - sps, gate_len and loop_end are sampled at each step start.
//    - loop_end lowered below the current step: wrap occurs at the next boundary.
//  - Counters saturate; they never wrap.
// CONFIGURATION
//  - SWING_STEP_EN defined: the swing port exists.
//    - Even steps last sps+swing ticks; odd steps last max(sps-swing,1) ticks.
//    - gate_len is applied unmodified.
//  - SWING_STEP_EN undefined: no swing port; every step lasts sps ticks.
// STRUCTURE
//  - Package rocket_seq_pkg:
//    - state encoding localparams
//    - entry field offsets (GATE_BIT = FREQ_BITS+1, TIE_BIT = FREQ_BITS)
//    - the ADDR_BITS = $clog2(STEPS) helper
//  - Sub-module lrclk_tick: 2-FF synchroniser plus rising-edge pulse generator; reused by other lrclk-paced controllers.
// TESTING
//  1. Reset, then write step0 {1,0,0x0222}, set loop_end=0, sps=4, gate_len=2, pulse start, drive 48 kHz lrclk
//     -> freq=0x0222; gate high 2 ticks, low 2 ticks; repeats; step_strobe every 4 ticks.
//  2. Steps 0..3 gated, tie=0, sps=gate_len=8, loop_end=3
//     -> gate low exactly 1 tick at each boundary; step goes 0,1,2,3,0.
//  3. Step1 tie=1, same setup as 2
//     -> no gate drop at the 0->1 boundary; freq changes on the step_strobe clk.
//  4. stop asserted mid-GATE_HI, and start+stop in the same clk
//     -> next clk gate=0, running=0, step=0; freq unchanged.
//  5. sps=0, gate_len=0, entry.gate=1
//     -> steps advance every tick; gate stays 0.
//  6. SWING_STEP_EN, sps=6, swing=2
//     -> step lengths alternate 8,4. swing=9 -> 15,1.

Source files
------------

// File: rtl/rocket_seq_pkg.sv
// rocket_seq_pkg
//   Shared definitions for the pattern step sequencer.
//   - Sequencer state encoding (localparams plus the enum built on them).
//   - Pattern entry layout: {gate, tie, freq}; bit positions derive from FREQ_BITS.
//   - addr_bits(): pattern index width for a given pattern depth.
//   No ports; imported by step_sequencer.

package rocket_seq_pkg;

  localparam logic [2:0] ENC_STOPPED = 3'd0;
  localparam logic [2:0] ENC_ARMED   = 3'd1;
  localparam logic [2:0] ENC_GATE_HI = 3'd2;
  localparam logic [2:0] ENC_GATE_LO = 3'd3;
  localparam logic [2:0] ENC_RETRIG  = 3'd4;

  typedef enum logic [2:0] {
    STOPPED = ENC_STOPPED,
    ARMED   = ENC_ARMED,
    GATE_HI = ENC_GATE_HI,
    GATE_LO = ENC_GATE_LO,
    RETRIG  = ENC_RETRIG
  } seq_state_t;

  // Entry field offsets: freq occupies [FREQ_BITS-1:0], then tie, then gate.
  function automatic int gate_bit(input int freq_bits);
    return freq_bits + 1;
  endfunction

  function automatic int tie_bit(input int freq_bits);
    return freq_bits;
  endfunction

  // Width of a pattern index; a one-entry pattern still needs one bit.
  function automatic int addr_bits(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/step_sequencer_lrclk_tick.sv
// lrclk_tick
//   Turns the asynchronous DACLRC into a one-clk sample tick in the clk domain.
//   Two-flop synchroniser, then a rising-edge detector with a registered output,
//   so tick pulses three clk edges after lrclk rises.
// Ports
//   clk    in   system clock
//   rst    in   synchronous reset, active high
//   lrclk  in   DACLRC, asynchronous to clk
//   tick   out  one-clk pulse per lrclk rising edge

module lrclk_tick (
  input  logic clk,
  input  logic rst,
  input  logic lrclk,
  output logic tick
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      tick      <= 1'b0;
    end else begin
      sync_1    <= lrclk;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      tick      <= sync_2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer
//   Plays a stored note pattern into the voice datapath at a sample-counted
//   tempo. Each step presents a frequency word and drives the envelope gate.
//   Optional feature macro: SWING_STEP_EN adds the swing port; even steps are
//   lengthened and odd steps shortened by the swing amount.
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   lrclk                 DACLRC; each rising edge is one sample tick
//   start / stop          playback control pulses (stop wins)
//   wr_en/wr_addr/wr_data pattern write port, entry = {gate, tie, freq}
//   sps                   samples per step (0 behaves as 1)
//   gate_len              samples the gate stays high within a step
//   loop_end              last step index before wrapping to 0
//   swing                 swing samples (SWING_STEP_EN builds only)
//   freq, gate            current frequency word and envelope gate
//   step, step_strobe     current step index and one-clk step-start pulse
//   running               high while playing

module step_sequencer
  import rocket_seq_pkg::*;
#(
  parameter int STEPS     = 16,
  parameter int FREQ_BITS = 16,
  parameter int CNT_BITS  = 16,
  localparam int ADDR_BITS = addr_bits(STEPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lrclk,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [FREQ_BITS+1:0] wr_data,
  input  logic [CNT_BITS-1:0]  sps,
  input  logic [CNT_BITS-1:0]  gate_len,
  input  logic [ADDR_BITS-1:0] loop_end,
`ifdef SWING_STEP_EN
  input  logic [7:0]           swing,
`endif
  output logic [FREQ_BITS-1:0] freq,
  output logic                 gate,
  output logic [ADDR_BITS-1:0] step,
  output logic                 step_strobe,
  output logic                 running
);

  localparam int GATE_BIT = gate_bit(FREQ_BITS);
  localparam int TIE_BIT  = tie_bit(FREQ_BITS);
  localparam int LEN_BITS = CNT_BITS + 1;

  seq_state_t state;
  seq_state_t state_next;
  seq_state_t start_state;

  logic                 tick;
  logic [FREQ_BITS+1:0] pattern_mem [STEPS];
  logic [FREQ_BITS+1:0] entry;
  logic [CNT_BITS-1:0]  tick_cnt;
  logic [CNT_BITS-1:0]  cnt_next;
  logic [LEN_BITS-1:0]  step_len;
  logic [LEN_BITS-1:0]  new_len;
  logic [CNT_BITS-1:0]  gate_len_s;
  logic [CNT_BITS-1:0]  sps_eff;
  logic [ADDR_BITS-1:0] load_idx;
  logic                 boundary;
  logic                 load;

  lrclk_tick u_tick (
    .clk   (clk),
    .rst   (rst),
    .lrclk (lrclk),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pattern_mem[wr_addr] <= wr_data;
    end
  end

  // Step timing. The tick counter saturates instead of wrapping, and the
  // step length carries one extra bit so sps plus swing cannot overflow.
  // A step ends on the tick that brings the count up to the step length.
  // Indexes cannot exceed STEPS-1, so comparing against loop_end already
  // clamps it; >= also wraps a step left beyond a lowered loop_end.
  always_comb begin
    cnt_next = (tick_cnt == {CNT_BITS{1'b1}}) ? tick_cnt : tick_cnt + CNT_BITS'(1);
    boundary = tick && ({1'b0, cnt_next} >= step_len);
    load_idx = ((state == ARMED) || (step >= loop_end)) ? '0 : step + ADDR_BITS'(1);
    entry    = pattern_mem[load_idx];
    sps_eff  = (sps == '0) ? CNT_BITS'(1) : sps;
`ifdef SWING_STEP_EN
    if (!load_idx[0]) begin
      new_len = {1'b0, sps_eff} + LEN_BITS'(swing);
    end else if ({1'b0, sps_eff} > LEN_BITS'(swing)) begin
      new_len = {1'b0, sps_eff} - LEN_BITS'(swing);
    end else begin
      new_len = LEN_BITS'(1);
    end
`else
    new_len = {1'b0, sps_eff};
`endif
  end

  // Where a freshly loaded step begins. A tied entry keeps a sounding gate
  // high (legato); an untied one re-attacks through a one-tick gap.
  always_comb begin
    start_state = GATE_LO;
    if (entry[GATE_BIT] && (gate_len != '0)) begin
      if ((state == GATE_HI) && !entry[TIE_BIT]) begin
        start_state = RETRIG;
      end else begin
        start_state = GATE_HI;
      end
    end
  end

  // Next-state logic. stop beats start, and both beat anything tick-driven.
  // A step boundary takes priority over the gate-length timeout.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    if (stop) begin
      state_next = STOPPED;
    end else if (start) begin
      state_next = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (tick) begin
            load       = 1'b1;
            state_next = start_state;
          end
        end
        GATE_HI: begin
          if (boundary) begin
            load       = 1'b1;
            state_next = start_state;
          end else if (tick && (cnt_next >= gate_len_s)) begin
            state_next = GATE_LO;
          end
        end
        GATE_LO: begin
          if (boundary) begin
            load       = 1'b1;
            state_next = start_state;
          end
        end
        RETRIG: begin
          if (boundary) begin
            load       = 1'b1;
            state_next = start_state;
          end else if (tick) begin
            state_next = (cnt_next < gate_len_s) ? GATE_HI : GATE_LO;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // State register and step datapath. The entry, sps and gate_len are all
  // captured at step start; freq is left alone by stop so a release tail
  // keeps its pitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= STOPPED;
      freq        <= '0;
      gate        <= 1'b0;
      step        <= '0;
      step_strobe <= 1'b0;
      running     <= 1'b0;
      tick_cnt    <= '0;
      step_len    <= LEN_BITS'(1);
      gate_len_s  <= '0;
    end else begin
      state       <= state_next;
      gate        <= (state_next == GATE_HI);
      running     <= (state_next != STOPPED);
      step_strobe <= load;
      if (stop || start) begin
        step <= '0;
      end else if (load) begin
        step       <= load_idx;
        freq       <= entry[FREQ_BITS-1:0];
        tick_cnt   <= '0;
        step_len   <= new_len;
        gate_len_s <= gate_len;
      end else if (tick) begin
        tick_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer
//   Self-checking bench for step_sequencer. A behavioural model tracks the
//   playback position within each step and derives gate, freq and step from
//   the musical rules; every clock the DUT outputs are compared to it.

module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lrclk;
  logic        start;
  logic        stop;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [17:0] wr_data;
  logic [15:0] sps;
  logic [15:0] gate_len;
  logic [3:0]  loop_end;
`ifdef SWING_STEP_EN
  logic [7:0]  swing;
`endif
  logic [15:0] freq;
  logic        gate;
  logic [3:0]  step;
  logic        step_strobe;
  logic        running;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [17:0] pat [16];
  logic [15:0] m_freq;
  logic        m_gate;
  logic [3:0]  m_step;
  logic        m_strobe;
  logic        m_running;
  bit          armed;
  bit          playing;
  int          pos;
  int          cur_len;
  int          cur_gl;
  bit          cur_en;

  // Stimulus bookkeeping
  int  cyc = 0;
  int  tick_due[$];
  bit  lr_run = 0;
  int  lr_cnt = 0;
  int  lr_half = 4;
  int  tick_ctr = 0;
  int  last_gap = 0;

  step_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .lrclk       (lrclk),
    .start       (start),
    .stop        (stop),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sps         (sps),
    .gate_len    (gate_len),
    .loop_end    (loop_end),
`ifdef SWING_STEP_EN
    .swing       (swing),
`endif
    .freq        (freq),
    .gate        (gate),
    .step        (step),
    .step_strobe (step_strobe),
    .running     (running)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkOutput();
    check_val("freq", 32'(freq), 32'(m_freq));
    check_val("gate", 32'(gate), 32'(m_gate));
    check_val("step", 32'(step), 32'(m_step));
    check_val("step_strobe", 32'(step_strobe), 32'(m_strobe));
    check_val("running", 32'(running), 32'(m_running));
  endtask

  // Start a step: new pitch every step; the gate opens unless the entry is
  // silent, gate_len is zero, or an untied note must re-attack after a
  // sounding one (one silent tick first).
  task automatic begin_step(input int s, input bit prev_gate);
    logic [17:0] e;
    int se;
    e  = pat[s];
    se = (sps == 16'd0) ? 1 : int'(sps);
`ifdef SWING_STEP_EN
    if (s % 2 == 0) cur_len = se + int'(swing);
    else cur_len = (se - int'(swing) < 1) ? 1 : se - int'(swing);
`else
    cur_len = se;
`endif
    cur_gl   = int'(gate_len);
    cur_en   = e[17];
    m_freq   = e[15:0];
    m_step   = 4'(s);
    pos      = 0;
    m_strobe = 1'b1;
    m_gate   = e[17] && (cur_gl > 0) && !(prev_gate && !e[16]);
  endtask

  task automatic model_clk(input bit t);
    int nxt;
    m_strobe = 1'b0;
    if (rst) begin
      m_freq = '0; m_gate = 0; m_step = '0; m_running = 0;
      armed = 0; playing = 0;
    end else if (stop) begin
      m_gate = 0; m_running = 0; m_step = '0; armed = 0; playing = 0;
    end else if (start) begin
      m_gate = 0; m_running = 1; m_step = '0; armed = 1; playing = 0;
    end else if (t && armed) begin
      armed = 0; playing = 1;
      begin_step(0, 1'b0);
    end else if (t && playing) begin
      if (pos < 65535) pos++;
      if (pos >= cur_len) begin
        nxt = (int'(m_step) >= int'(loop_end)) ? 0 : int'(m_step) + 1;
        begin_step(nxt, m_gate);
      end else begin
        m_gate = cur_en && (pos < cur_gl);
      end
    end
    if (wr_en) pat[wr_addr] = wr_data;
  endtask

  // One or more clocks: advance lrclk, clock, update model, compare.
  task automatic applyStimulus(input int n);
    bit t;
    repeat (n) begin
      if (lr_run) begin
        lr_cnt++;
        if (lr_cnt >= lr_half) begin
          lr_cnt = 0;
          lrclk = ~lrclk;
          if (lrclk) tick_due.push_back(cyc + 4);
        end
      end
      @(posedge clk);
      cyc++;
      t = 0;
      if (tick_due.size() > 0 && tick_due[0] == cyc) begin
        t = 1;
        void'(tick_due.pop_front());
      end
      model_clk(t);
      if (t) tick_ctr++;
      #1;
      checkOutput();
      if (step_strobe === 1'b1) begin
        last_gap = tick_ctr;
        tick_ctr = 0;
      end
      start = 0; stop = 0; wr_en = 0;
    end
  endtask

  task automatic write_entry(input int a, input bit g, input bit ti, input logic [15:0] f);
    wr_en = 1; wr_addr = 4'(a); wr_data = {g, ti, f};
    applyStimulus(1);
  endtask

  task automatic wait_strobe(input string tag);
    int budget;
    budget = 400;
    applyStimulus(1);
    while (step_strobe !== 1'b1 && budget > 0) begin
      applyStimulus(1);
      budget--;
    end
    check_val(tag, 32'(step_strobe), 32'd1);
  endtask

  initial begin
    logic [15:0] held;
    int budget;
    rst = 1; lrclk = 0; start = 0; stop = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    sps = 16'd4; gate_len = 16'd2; loop_end = 4'd0;
`ifdef SWING_STEP_EN
    swing = 8'd0;
`endif
    applyStimulus(3);
    rst = 0;
    lr_run = 1;
    for (int a = 0; a < 16; a++) write_entry(a, 1'b0, 1'b0, 16'(a * 16'h0111));

    $display("[TB] single step pattern");
    write_entry(0, 1'b1, 1'b0, 16'h0222);
    loop_end = 4'd0; sps = 16'd4; gate_len = 16'd2; start = 1;
    applyStimulus(200);
    check_val("t1_freq", 32'(freq), 32'h0222);
    check_val("t1_gap", 32'(last_gap), 32'd4);
    check_val("t1_running", 32'(running), 32'd1);

    $display("[TB] four retriggered steps");
    for (int a = 0; a < 4; a++) write_entry(a, 1'b1, 1'b0, 16'($urandom));
    sps = 16'd8; gate_len = 16'd8; loop_end = 4'd3; start = 1;
    applyStimulus(320);
    check_val("t2_gap", 32'(last_gap), 32'd8);

    $display("[TB] tied step 1");
    write_entry(1, 1'b1, 1'b1, 16'($urandom));
    applyStimulus(300);

    $display("[TB] stop and start/stop collisions");
    budget = 200;
    while (m_gate !== 1'b1 && budget > 0) begin applyStimulus(1); budget--; end
    check_val("t4_gate_hi_seen", 32'(gate), 32'd1);
    held = m_freq;
    stop = 1;
    applyStimulus(1);
    check_val("t4_stop_gate", 32'(gate), 32'd0);
    check_val("t4_stop_run", 32'(running), 32'd0);
    check_val("t4_stop_freq", 32'(freq), 32'(held));
    start = 1;
    applyStimulus(60);
    held = m_freq;
    start = 1; stop = 1;
    applyStimulus(1);
    check_val("t4_both_run", 32'(running), 32'd0);
    check_val("t4_both_step", 32'(step), 32'd0);
    check_val("t4_both_freq", 32'(freq), 32'(held));

    $display("[TB] zero sps and gate_len");
    sps = 16'd0; gate_len = 16'd0; start = 1;
    applyStimulus(120);
    check_val("t5_gap", 32'(last_gap), 32'd1);
    check_val("t5_gate", 32'(gate), 32'd0);

`ifdef SWING_STEP_EN
    $display("[TB] swing");
    sps = 16'd6; gate_len = 16'd3; swing = 8'd2; loop_end = 4'd1; start = 1;
    wait_strobe("sw_start");
    for (int j = 0; j < 4; j++) begin
      wait_strobe("sw_strobe");
      check_val("sw2_gap", 32'(last_gap), (m_step == 4'd1) ? 32'd8 : 32'd4);
    end
    swing = 8'd9; start = 1;
    wait_strobe("sw_start9");
    for (int j = 0; j < 4; j++) begin
      wait_strobe("sw_strobe9");
      check_val("sw9_gap", 32'(last_gap), (m_step == 4'd1) ? 32'd15 : 32'd1);
    end
    swing = 8'd0;
`endif

    $display("[TB] randomized playback");
    for (int a = 0; a < 16; a++) write_entry(a, 1'($urandom), 1'($urandom), 16'($urandom));
    sps = 16'd3; gate_len = 16'd2; loop_end = 4'd7; start = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) start = 1;
      if ($urandom_range(0, 399) == 0) stop = 1;
      if (!m_running && $urandom_range(0, 19) == 0) start = 1;
      if ($urandom_range(0, 9) == 0) begin
        wr_en = 1; wr_addr = 4'($urandom); wr_data = 18'($urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        sps = 16'($urandom_range(0, 7));
        gate_len = 16'($urandom_range(0, 10));
        loop_end = 4'($urandom);
      end
      if ($urandom_range(0, 199) == 0) lr_half = $urandom_range(2, 5);
`ifdef SWING_STEP_EN
      if ($urandom_range(0, 199) == 0) swing = 8'($urandom_range(0, 9));
`endif
      applyStimulus(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
